// File: rtl/aq_djpeg_pkg.sv
// aq_djpeg_pkg: shared slot codes, FSM states and config constants for the JPEG MCU scheduler
// Helper ceil_shr(v, k) returns ceil(v / 2**k) using only a shift and an add.
package aq_djpeg_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CFG, S_WAIT, S_GRANT, S_XFER, S_DONE, S_ERR} state_e;
   localparam logic [2:0] SLOT_Y0 = 3'd0, SLOT_Y1 = 3'd1, SLOT_Y2 = 3'd2, SLOT_Y3 = 3'd3;
   localparam logic [2:0] SLOT_CB = 3'd4, SLOT_CR = 3'd5;
   localparam logic [2:0] JPEG_COMP_GREY = 3'd1, JPEG_COMP_YCC = 3'd3;
   function automatic logic [15:0] ceil_shr(input logic [15:0] v, input logic [2:0] k);
      logic [16:0] s;
      s = ({1'b0, v} + ~(17'h1ffff << k)) >> k;
      return s[15:0];
   endfunction
endpackage

// File: rtl/aq_djpeg_mcu_slot.sv
// aq_djpeg_mcu_slot: next colour slot and last-slot flag within one MCU
// Ports: slot_i current slot, comp_i JpegComp, sw_i/sh_i luma subsampling,
//        next_o slot following slot_i (wraps to Y0), last_o slot_i ends the MCU.
module aq_djpeg_mcu_slot
   import aq_djpeg_pkg::*;
(
   input  logic [2:0] slot_i,
   input  logic [2:0] comp_i,
   input  logic [1:0] sw_i,
   input  logic [1:0] sh_i,
   output logic [2:0] next_o,
   output logic       last_o
);
   logic grey, w2, h2;
   assign grey = comp_i == JPEG_COMP_GREY;
   assign w2 = sw_i == 2'd2;
   assign h2 = sh_i == 2'd2;
   assign last_o = grey ? slot_i == SLOT_Y3 : slot_i == SLOT_CR;
   // Luma blocks are numbered row-major in a 2x2 grid, so W1H2 skips Y1 and goes straight to Y2.
   assign next_o = last_o ? SLOT_Y0 :
                   grey ? slot_i + 3'd1 :
                   slot_i == SLOT_Y0 ? (w2 ? SLOT_Y1 : h2 ? SLOT_Y2 : SLOT_CB) :
                   slot_i == SLOT_Y1 ? (h2 ? SLOT_Y2 : SLOT_CB) :
                   slot_i == SLOT_Y2 ? (w2 ? SLOT_Y3 : SLOT_CB) :
                   slot_i + 3'd1;
endmodule

// File: rtl/aq_djpeg_mcu_seq.sv
// aq_djpeg_mcu_seq: per-frame MCU scheduler granting IDCT block write slots
// Ports: clk/rst (sync, active-high); ProcessInit starts a frame and latches JpegComp,
//        SubSamplingW/H, ImageWidth/Height; BlockReq/BlockDone/BankFull handshake with IDCT
//        and buffer; BlockGrant pulse, BlockColor slot, McuX/McuY position, McuBlockWidth,
//        Busy, FrameDone pulse, sticky CfgError.
module aq_djpeg_mcu_seq
   import aq_djpeg_pkg::*;
#(
   parameter int BW = 12
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          ProcessInit,
   input  logic [2:0]    JpegComp,
   input  logic [1:0]    SubSamplingW,
   input  logic [1:0]    SubSamplingH,
   input  logic [15:0]   ImageWidth,
   input  logic [15:0]   ImageHeight,
   input  logic          BlockReq,
   input  logic          BlockDone,
   input  logic          BankFull,
   output logic          BlockGrant,
   output logic [2:0]    BlockColor,
   output logic [BW-1:0] McuX,
   output logic [BW-1:0] McuY,
   output logic [BW-1:0] McuBlockWidth,
   output logic          Busy,
   output logic          FrameDone,
   output logic          CfgError
);
   localparam logic [BW-1:0] ONE = BW'(1);
   state_e state_q, state_d;
   logic [2:0] comp_q, comp_d, slot_q, slot_d, slot_nxt, wk, hk;
   logic [1:0] sw_q, sw_d, sh_q, sh_d;
   logic [15:0] wid_q, wid_d, hgt_q, hgt_d;
   logic [BW-1:0] x_q, x_d, y_q, y_d, mbw_q, mbw_d, rows_q, rows_d;
   logic grant_q, grant_d, done_q, done_d, busy_q, busy_d, err_q, err_d, slot_last, cfg_ok;
   aq_djpeg_mcu_slot u_slot (
      .slot_i (slot_q),
      .comp_i (comp_q),
      .sw_i   (sw_q),
      .sh_i   (sh_q),
      .next_o (slot_nxt),
      .last_o (slot_last)
   );
   assign cfg_ok = comp_q == JPEG_COMP_GREY ||
                   (comp_q == JPEG_COMP_YCC && sw_q inside {2'd1, 2'd2} && sh_q inside {2'd1, 2'd2});
   // log2 of MCU size in pixels: grey units are 32 wide by 8 high
   assign wk = comp_q == JPEG_COMP_GREY ? 3'd5 : sw_q == 2'd2 ? 3'd4 : 3'd3;
   assign hk = comp_q != JPEG_COMP_GREY && sh_q == 2'd2 ? 3'd4 : 3'd3;
   always_comb begin
      state_d = state_q;
      comp_d = comp_q;
      sw_d = sw_q;
      sh_d = sh_q;
      wid_d = wid_q;
      hgt_d = hgt_q;
      slot_d = slot_q;
      x_d = x_q;
      y_d = y_q;
      mbw_d = mbw_q;
      rows_d = rows_q;
      err_d = err_q;
      if (ProcessInit) begin
         state_d = S_CFG;
         comp_d = JpegComp;
         sw_d = SubSamplingW;
         sh_d = SubSamplingH;
         wid_d = ImageWidth;
         hgt_d = ImageHeight;
         slot_d = SLOT_Y0;
         x_d = '0;
         y_d = '0;
         err_d = 1'b0;
      end else begin
         case (state_q)
            S_CFG: begin
               mbw_d = BW'(ceil_shr(wid_q, wk));
               rows_d = BW'(ceil_shr(hgt_q, hk));
               state_d = cfg_ok ? S_WAIT : S_ERR;
               err_d = !cfg_ok;
            end
            S_WAIT: state_d = BlockReq && !BankFull ? S_GRANT : S_WAIT;
            S_GRANT: state_d = S_XFER;
            S_XFER: if (BlockDone) begin
               slot_d = slot_nxt;
               state_d = S_WAIT;
               if (slot_last) begin
                  if (x_q != mbw_q - ONE) x_d = x_q + ONE;
                  else if (y_q != rows_q - ONE) begin
                     x_d = '0;
                     y_d = y_q + ONE;
                  end else state_d = S_DONE;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
      // outputs are registered from the next state so they line up with it
      grant_d = state_d == S_GRANT;
      done_d = state_d == S_DONE;
      busy_d = state_d inside {S_CFG, S_WAIT, S_GRANT, S_XFER};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         comp_q <= '0;
         sw_q <= '0;
         sh_q <= '0;
         wid_q <= '0;
         hgt_q <= '0;
         slot_q <= '0;
         x_q <= '0;
         y_q <= '0;
         mbw_q <= '0;
         rows_q <= '0;
         grant_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         comp_q <= comp_d;
         sw_q <= sw_d;
         sh_q <= sh_d;
         wid_q <= wid_d;
         hgt_q <= hgt_d;
         slot_q <= slot_d;
         x_q <= x_d;
         y_q <= y_d;
         mbw_q <= mbw_d;
         rows_q <= rows_d;
         grant_q <= grant_d;
         done_q <= done_d;
         busy_q <= busy_d;
         err_q <= err_d;
      end
   end
   assign BlockGrant = grant_q;
   assign BlockColor = slot_q;
   assign McuX = x_q;
   assign McuY = y_q;
   assign McuBlockWidth = mbw_q;
   assign Busy = busy_q;
   assign FrameDone = done_q;
   assign CfgError = err_q;
endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// tb_aq_djpeg_mcu_seq: randomized self-checking bench for the MCU scheduler
module tb_aq_djpeg_mcu_seq;
   localparam int BW = 12;
   logic clk = 1'b0, rst = 1'b1, ProcessInit = 1'b0;
   logic [2:0] JpegComp = '0;
   logic [1:0] SubSamplingW = '0, SubSamplingH = '0;
   logic [15:0] ImageWidth = '0, ImageHeight = '0;
   logic BlockReq = 1'b0, BlockDone = 1'b0, BankFull = 1'b0;
   logic BlockGrant, Busy, FrameDone, CfgError;
   logic [2:0] BlockColor;
   logic [BW-1:0] McuX, McuY, McuBlockWidth;
   always #5 clk = ~clk;
   aq_djpeg_mcu_seq #(.BW(BW)) dut (
      .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .JpegComp(JpegComp),
      .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
      .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
      .BlockReq(BlockReq), .BlockDone(BlockDone), .BankFull(BankFull),
      .BlockGrant(BlockGrant), .BlockColor(BlockColor), .McuX(McuX), .McuY(McuY),
      .McuBlockWidth(McuBlockWidth), .Busy(Busy), .FrameDone(FrameDone), .CfgError(CfgError)
   );
   int n_chk = 0, n_pass = 0;
   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
   endfunction
   // Frame model: ordered list of (colour, x, y) for every block of a frame
   int m_col[$], m_x[$], m_y[$];
   int m_mw;
   bit m_ok;
   function automatic void build(int comp, int sw, int sh, int w, int h);
      int seq[$];
      int mh;
      m_col.delete();
      m_x.delete();
      m_y.delete();
      m_ok = comp == 1 || (comp == 3 && sw inside {1, 2} && sh inside {1, 2});
      if (!m_ok) return;
      if (comp == 1) begin
         m_mw = (w + 31) / 32;
         mh = (h + 7) / 8;
         seq = '{0, 1, 2, 3};
      end else begin
         m_mw = (w + 8 * sw - 1) / (8 * sw);
         mh = (h + 8 * sh - 1) / (8 * sh);
         for (int v = 0; v < sh; v++)
            for (int u = 0; u < sw; u++) seq.push_back(2 * v + u);
         seq.push_back(4);
         seq.push_back(5);
      end
      for (int y = 0; y < mh; y++)
         for (int x = 0; x < m_mw; x++)
            foreach (seq[i]) begin
               m_col.push_back(seq[i]);
               m_x.push_back(x);
               m_y.push_back(y);
            end
   endfunction
   function automatic int nblocks(int comp, int sw, int sh, int w, int h);
      if (comp == 1) return ((w + 31) / 32) * ((h + 7) / 8) * 4;
      return ((w + 8 * sw - 1) / (8 * sw)) * ((h + 8 * sh - 1) / (8 * sh)) * (sw * sh + 2);
   endfunction
   // Cycle model of the frame protocol; checks every output after every edge
   typedef enum {M_IDLE, M_CFG, M_WAIT, M_GRANT, M_XFER, M_DONE, M_ERR} mode_t;
   mode_t mode = M_IDLE;
   int k = 0, ex = 0, ey = 0, ecol = 0, embw = 0;
   bit col_known = 1'b1, mbw_known = 1'b1;
   initial forever begin
      @(posedge clk);
      if (rst) begin
         mode = M_IDLE;
         ex = 0;
         ey = 0;
         ecol = 0;
         embw = 0;
         col_known = 1'b1;
         mbw_known = 1'b1;
      end else if (ProcessInit) begin
         build(int'(JpegComp), int'(SubSamplingW), int'(SubSamplingH), int'(ImageWidth), int'(ImageHeight));
         mode = M_CFG;
         k = 0;
         ex = 0;
         ey = 0;
         ecol = 0;
         col_known = 1'b1;
         mbw_known = 1'b0;
      end else begin
         case (mode)
            M_CFG: if (m_ok) begin
               mode = M_WAIT;
               embw = m_mw;
               mbw_known = 1'b1;
            end else mode = M_ERR;
            M_WAIT: if (BlockReq && !BankFull) mode = M_GRANT;
            M_GRANT: mode = M_XFER;
            M_XFER: if (BlockDone) begin
               k++;
               mode = k == m_col.size() ? M_DONE : M_WAIT;
               if (mode == M_DONE) col_known = 1'b0;
            end
            M_DONE: mode = M_IDLE;
            default: mode = mode;
         endcase
      end
      if (mode inside {M_WAIT, M_GRANT, M_XFER}) begin
         ecol = m_col[k];
         ex = m_x[k];
         ey = m_y[k];
      end
      #1;
      chk("grant", BlockGrant, mode == M_GRANT);
      chk("frame_done", FrameDone, mode == M_DONE);
      chk("busy", Busy, mode inside {M_CFG, M_WAIT, M_GRANT, M_XFER});
      chk("cfg_error", CfgError, mode == M_ERR);
      chk("mcu_x", McuX, ex);
      chk("mcu_y", McuY, ey);
      if (col_known) chk("color", BlockColor, ecol);
      if (mbw_known) chk("mcu_width", McuBlockWidth, embw);
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   int gcol[$];
   task automatic run_frame(int comp, int sw, int sh, int w, int h, int full_pct, bit hold,
                            int ab_blk, int ab_kind);
      int blk, t, nb, kind;
      JpegComp = 3'(comp);
      SubSamplingW = 2'(sw);
      SubSamplingH = 2'(sh);
      ImageWidth = 16'(w);
      ImageHeight = 16'(h);
      BlockReq = 1'b0;
      BankFull = 1'b0;
      BlockDone = 1'b0;
      ProcessInit = 1'b1;
      step();
      ProcessInit = 1'b0;
      gcol.delete();
      blk = 0;
      kind = ab_kind;
      nb = nblocks(comp, sw, sh, w, h);
      if (hold) begin
         BlockReq = 1'b1;
         BankFull = 1'b1;
         repeat (10) begin
            step();
            chk("no_grant_while_full", BlockGrant, 0);
         end
         BankFull = 1'b0;
         step();
         chk("grant_after_release", BlockGrant, 1);
      end
      forever begin
         t = 0;
         while (!BlockGrant && !FrameDone && t < 300) begin
            BlockReq = $urandom_range(0, 3) != 0;
            BankFull = $urandom_range(0, 99) < full_pct;
            BlockDone = $urandom_range(0, 7) == 0;
            step();
            t++;
         end
         BlockDone = 1'b0;
         if (FrameDone) break;
         if (!BlockGrant) begin
            chk("grant_timeout", BlockGrant, 1);
            return;
         end
         gcol.push_back(int'(BlockColor));
         BlockReq = $urandom_range(0, 1) != 0;
         BankFull = $urandom_range(0, 1) != 0;
         step();
         if (kind != 0 && blk == ab_blk) begin
            if (kind == 1) begin
               chk("abort_slot", BlockColor, 2);
               ProcessInit = 1'b1;
               step();
               ProcessInit = 1'b0;
               chk("abort_busy", Busy, 1);
               chk("abort_x", McuX, 0);
               chk("abort_y", McuY, 0);
               blk = 0;
               kind = 0;
               gcol.delete();
               continue;
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_busy", Busy, 0);
            chk("rst_x", McuX, 0);
            return;
         end
         repeat ($urandom_range(0, 4)) begin
            BlockReq = $urandom_range(0, 1) != 0;
            step();
         end
         BlockDone = 1'b1;
         BlockReq = $urandom_range(0, 1) != 0;
         step();
         BlockDone = 1'b0;
         blk++;
      end
      chk("blocks_in_frame", blk, nb);
      step();
      chk("frame_done_once", FrameDone, 0);
   endtask
   task automatic run_err(int comp, int sw);
      int ng;
      JpegComp = 3'(comp);
      SubSamplingW = 2'(sw);
      SubSamplingH = 2'd1;
      ImageWidth = 16'd16;
      ImageHeight = 16'd16;
      ProcessInit = 1'b1;
      step();
      ProcessInit = 1'b0;
      BlockReq = 1'b1;
      BankFull = 1'b0;
      ng = 0;
      repeat (20) begin
         step();
         if (BlockGrant) ng++;
      end
      chk("err_flag", CfgError, 1);
      chk("err_busy", Busy, 0);
      chk("err_grants", ng, 0);
      BlockReq = 1'b0;
   endtask
   initial begin
      int pat[4];
      pat = '{0, 1, 4, 5};
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_grant", BlockGrant, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_width", McuBlockWidth, 0);
      build(3, 2, 2, 16, 16);
      chk("model_420_len", m_col.size(), 6);
      foreach (m_col[i]) chk("model_420_col", m_col[i], i);
      build(3, 2, 1, 40, 8);
      chk("model_422_mw", m_mw, 3);
      chk("model_422_col5", m_col[5], 1);
      chk("model_422_x4", m_x[4], 1);
      build(1, 1, 1, 64, 16);
      chk("model_grey_mw", m_mw, 2);
      chk("model_grey_y15", m_y[15], 1);
      chk("model_grey_n", nblocks(1, 1, 1, 64, 16), 16);
      run_frame(3, 2, 2, 16, 16, 0, 1'b0, -1, 0);
      chk("420_width", McuBlockWidth, 1);
      chk("420_grants", gcol.size(), 6);
      foreach (gcol[i]) chk("420_color", gcol[i], i);
      run_frame(3, 2, 1, 40, 8, 20, 1'b0, -1, 0);
      chk("422_width", McuBlockWidth, 3);
      chk("422_final_x", McuX, 2);
      chk("422_final_y", McuY, 0);
      chk("422_grants", gcol.size(), 12);
      foreach (gcol[i]) chk("422_color", gcol[i], pat[i % 4]);
      run_frame(1, 1, 1, 64, 16, 20, 1'b0, -1, 0);
      chk("grey_width", McuBlockWidth, 2);
      chk("grey_final_y", McuY, 1);
      foreach (gcol[i]) chk("grey_color", gcol[i], i % 4);
      run_frame(3, 1, 1, 8, 8, 0, 1'b1, -1, 0);
      run_frame(3, 2, 2, 64, 64, 10, 1'b0, 32, 1);
      chk("after_abort_first_color", gcol[0], 0);
      run_err(2, 1);
      run_err(3, 3);
      run_frame(3, 1, 2, 24, 24, 20, 1'b0, -1, 0);
      chk("err_cleared", CfgError, 0);
      run_frame(3, 1, 1, 32, 16, 20, 1'b0, 3, 2);
      repeat (8) begin
         int comp;
         comp = $urandom_range(0, 1) != 0 ? 1 : 3;
         run_frame(comp, $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 80),
                   $urandom_range(1, 40), $urandom_range(0, 40), 1'b0, -1, 0);
      end
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
